mem_access_log: RTL and testbench

- Memory-stage access tracer for the pipelined RV32I core.
- Sits beside the data memory, snoops the MEM-stage address, write data and control (mem_ctrl_t) plus the memory's registered read data.
- Produces one formatted log record per load/store when that instruction reaches WB, and keeps load/store counters.
- Optional `SIMULATION` text print per record; the rest is synthesizable.

---
 rtl/mem_access_log_pkg.sv | 17 +
 rtl/mem_access_decode.sv | 38 +++
 rtl/mem_access_log.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_log.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_log_pkg.sv
// Shared core types for the memory-stage access tracer.
// Carries the MEM-stage control bundle and the access size encodings.
package mem_access_log_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic [1:0] size;
    logic       sign;   // 0 signed, 1 unsigned
  } mem_ctrl_t;

endpackage

// File: rtl/mem_access_decode.sv
// Combinational access decode: lanes touched, alignment and size legality, store-data mask.
// Zero latency; no flow control.
module mem_access_decode
  import mem_access_log_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  output logic [3:0]  o_byte_en,
  output logic        o_misaligned,
  output logic        o_bad_size,
  output logic [31:0] o_data_mask
);

  always_comb begin
    o_byte_en    = 4'b0000;
    o_misaligned = 1'b0;
    o_bad_size   = 1'b0;
    o_data_mask  = 32'hFFFF_FFFF;
    case (i_size)
      SIZE_B: begin
        o_byte_en   = 4'b0001 << i_addr_lo;
        o_data_mask = 32'h0000_00FF;
      end
      SIZE_H: begin
        o_byte_en    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_misaligned = i_addr_lo[0];
        o_data_mask  = 32'h0000_FFFF;
      end
      SIZE_W: begin
        o_byte_en    = 4'b1111;
        o_misaligned = (i_addr_lo != 2'b00);
      end
      // Illegal size: no lanes, store data passed through unmasked.
      default: o_bad_size = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_log.sv
// Snoops MEM-stage loads/stores into a one-entry pending slot and emits a log record when WB advances.
// Record appears the cycle after the emitting edge; no backpressure, an unemitted slot is overwritten and flagged.
module mem_access_log
  import mem_access_log_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit PRINT_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             en_MEM,
  input  logic             en_WB,
  input  logic [31:0]      i_memAddr,
  input  logic [31:0]      i_writeData,
  input  mem_ctrl_t        i_ctrlMEM,
  input  logic [31:0]      i_readData,
  output logic             o_logValid,
  output logic             o_logIsWrite,
  output logic [31:0]      o_logAddr,
  output logic [31:0]      o_logData,
  output logic [1:0]       o_logSize,
  output logic             o_logUnsigned,
  output logic [3:0]       o_logByteEn,
  output logic             o_logMisaligned,
  output logic             o_logBadSize,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_loadCount,
  output logic [CNT_W-1:0] o_storeCount
);

  logic        slot_full_q, slot_full_d;
  logic [31:0] slot_addr_q, slot_addr_d;
  logic [31:0] slot_wdata_q, slot_wdata_d;
  logic [1:0]  slot_size_q, slot_size_d;
  logic        slot_sign_q, slot_sign_d;
  logic        slot_wr_q, slot_wr_d;

  logic             log_valid_q, log_valid_d;
  logic             log_wr_q, log_wr_d;
  logic [31:0]      log_addr_q, log_addr_d;
  logic [31:0]      log_data_q, log_data_d;
  logic [1:0]       log_size_q, log_size_d;
  logic             log_uns_q, log_uns_d;
  logic [3:0]       log_be_q, log_be_d;
  logic             log_mis_q, log_mis_d;
  logic             log_bad_q, log_bad_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;

  logic        capture, emit;
  logic [3:0]  dec_be;
  logic        dec_mis, dec_bad;
  logic [31:0] dec_mask;

  // Decode runs on the pending slot so the record reflects what was captured.
  mem_access_decode u_decode (
    .i_size       (slot_size_q),
    .i_addr_lo    (slot_addr_q[1:0]),
    .o_byte_en    (dec_be),
    .o_misaligned (dec_mis),
    .o_bad_size   (dec_bad),
    .o_data_mask  (dec_mask)
  );

  always_comb begin
    capture      = en_MEM & (i_ctrlMEM.memRead | i_ctrlMEM.memWrite);
    emit         = en_WB & slot_full_q;

    slot_full_d  = slot_full_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    slot_size_d  = slot_size_q;
    slot_sign_d  = slot_sign_q;
    slot_wr_d    = slot_wr_q;
    log_valid_d  = emit;
    log_wr_d     = log_wr_q;
    log_addr_d   = log_addr_q;
    log_data_d   = log_data_q;
    log_size_d   = log_size_q;
    log_uns_d    = log_uns_q;
    log_be_d     = log_be_q;
    log_mis_d    = log_mis_q;
    log_bad_d    = log_bad_q;
    overrun_d    = overrun_q | (capture & slot_full_q & ~emit);
    load_cnt_d   = load_cnt_q;
    store_cnt_d  = store_cnt_q;

    if (emit) begin
      log_wr_d   = slot_wr_q;
      log_addr_d = slot_addr_q;
      log_data_d = slot_wr_q ? (slot_wdata_q & dec_mask) : i_readData;
      log_size_d = slot_size_q;
      log_uns_d  = slot_sign_q;
      log_be_d   = dec_be;
      log_mis_d  = dec_mis;
      log_bad_d  = dec_bad;
      if (slot_wr_q) store_cnt_d = store_cnt_q + CNT_W'(1);
      else           load_cnt_d  = load_cnt_q + CNT_W'(1);
      slot_full_d = 1'b0;
    end

    // A capture on the emit edge refills the slot after the old record has left.
    if (capture) begin
      slot_full_d  = 1'b1;
      slot_addr_d  = i_memAddr;
      slot_wdata_d = i_writeData;
      slot_size_d  = i_ctrlMEM.size;
      slot_sign_d  = i_ctrlMEM.sign;
      slot_wr_d    = i_ctrlMEM.memWrite;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      slot_full_q  <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      slot_size_q  <= '0;
      slot_sign_q  <= 1'b0;
      slot_wr_q    <= 1'b0;
      log_valid_q  <= 1'b0;
      log_wr_q     <= 1'b0;
      log_addr_q   <= '0;
      log_data_q   <= '0;
      log_size_q   <= '0;
      log_uns_q    <= 1'b0;
      log_be_q     <= '0;
      log_mis_q    <= 1'b0;
      log_bad_q    <= 1'b0;
      overrun_q    <= 1'b0;
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
    end else begin
      slot_full_q  <= slot_full_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      slot_size_q  <= slot_size_d;
      slot_sign_q  <= slot_sign_d;
      slot_wr_q    <= slot_wr_d;
      log_valid_q  <= log_valid_d;
      log_wr_q     <= log_wr_d;
      log_addr_q   <= log_addr_d;
      log_data_q   <= log_data_d;
      log_size_q   <= log_size_d;
      log_uns_q    <= log_uns_d;
      log_be_q     <= log_be_d;
      log_mis_q    <= log_mis_d;
      log_bad_q    <= log_bad_d;
      overrun_q    <= overrun_d;
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
    end
  end

  assign o_logValid      = log_valid_q;
  assign o_logIsWrite    = log_wr_q;
  assign o_logAddr       = log_addr_q;
  assign o_logData       = log_data_q;
  assign o_logSize       = log_size_q;
  assign o_logUnsigned   = log_uns_q;
  assign o_logByteEn     = log_be_q;
  assign o_logMisaligned = log_mis_q;
  assign o_logBadSize    = log_bad_q;
  assign o_overrun       = overrun_q;
  assign o_loadCount     = load_cnt_q;
  assign o_storeCount    = store_cnt_q;

  generate
    if (PRINT_EN) begin : g_print
`ifdef SIMULATION
      always @(posedge i_clk) begin
        if (log_valid_q)
          $display("MEM %s addr=%08h data=%08h size=%0d",
                   log_wr_q ? "W" : "R", log_addr_q, log_data_q, log_size_q);
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_mem_access_log.sv
// Bench for mem_access_log: directed scenarios then random traffic against a record-level model.
module tb_mem_access_log;
  import mem_access_log_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        en_MEM = 1'b0;
  logic        en_WB = 1'b0;
  logic [31:0] i_memAddr = '0;
  logic [31:0] i_writeData = '0;
  mem_ctrl_t   i_ctrlMEM = '0;
  logic [31:0] i_readData = '0;
  logic        o_logValid, o_logIsWrite, o_logUnsigned, o_logMisaligned, o_logBadSize, o_overrun;
  logic [31:0] o_logAddr, o_logData, o_loadCount, o_storeCount;
  logic [1:0]  o_logSize;
  logic [3:0]  o_logByteEn;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_log #(.CNT_W(32), .PRINT_EN(1'b0)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .en_MEM(en_MEM), .en_WB(en_WB),
    .i_memAddr(i_memAddr), .i_writeData(i_writeData), .i_ctrlMEM(i_ctrlMEM),
    .i_readData(i_readData), .o_logValid(o_logValid), .o_logIsWrite(o_logIsWrite),
    .o_logAddr(o_logAddr), .o_logData(o_logData), .o_logSize(o_logSize),
    .o_logUnsigned(o_logUnsigned), .o_logByteEn(o_logByteEn),
    .o_logMisaligned(o_logMisaligned), .o_logBadSize(o_logBadSize),
    .o_overrun(o_overrun), .o_loadCount(o_loadCount), .o_storeCount(o_storeCount)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: one pending access plus the last published record.
  bit          s_full, s_wr, s_sign;
  bit [31:0]   s_addr, s_wdata;
  bit [1:0]    s_size;
  bit          e_valid, e_wr, e_uns, e_mis, e_bad, e_ovr;
  bit [31:0]   e_addr, e_data, e_lc, e_sc;
  bit [1:0]    e_size;
  bit [3:0]    e_be;

  // Lanes are the naturally aligned block of 2**size bytes containing the address.
  function automatic bit [3:0] lanes(bit [1:0] sz, bit [31:0] a);
    int n, off, base;
    bit [3:0] r = 4'b0000;
    if (sz == 2'b11) return 4'b0000;
    n    = 1 << sz;
    off  = int'(a % 4);
    base = off - (off % n);
    for (int i = 0; i < 4; i++)
      if (i >= base && i < base + n) r[i] = 1'b1;
    return r;
  endfunction

  function automatic bit [31:0] store_val(bit [1:0] sz, bit [31:0] d);
    case (sz)
      2'b00:   return d % 256;
      2'b01:   return d % 65536;
      default: return d;
    endcase
  endfunction

  task automatic model_edge(input bit rst, mem, wb, rd, wr, input bit [1:0] sz,
                            input bit sg, input bit [31:0] a, wd, rdat);
    bit emit, cap;
    if (rst) begin
      s_full = 0; s_wr = 0; s_sign = 0; s_addr = 0; s_wdata = 0; s_size = 0;
      e_valid = 0; e_wr = 0; e_uns = 0; e_mis = 0; e_bad = 0; e_ovr = 0;
      e_addr = 0; e_data = 0; e_lc = 0; e_sc = 0; e_size = 0; e_be = 0;
      return;
    end
    emit = wb && s_full;
    cap  = mem && (rd || wr);
    e_valid = emit;
    if (emit) begin
      e_wr   = s_wr;
      e_addr = s_addr;
      e_data = s_wr ? store_val(s_size, s_wdata) : rdat;
      e_size = s_size;
      e_uns  = s_sign;
      e_be   = lanes(s_size, s_addr);
      e_bad  = (s_size == 2'b11);
      e_mis  = !e_bad && (s_addr % (1 << s_size)) != 0;
      if (s_wr) e_sc++; else e_lc++;
      s_full = 0;
    end
    if (cap) begin
      if (s_full) e_ovr = 1;
      s_full = 1; s_addr = a; s_wdata = wd; s_size = sz; s_sign = sg; s_wr = wr;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("valid",    {31'b0, o_logValid},      {31'b0, e_valid});
    check("is_write", {31'b0, o_logIsWrite},    {31'b0, e_wr});
    check("addr",     o_logAddr,                e_addr);
    check("data",     o_logData,                e_data);
    check("size",     {30'b0, o_logSize},       {30'b0, e_size});
    check("unsigned", {31'b0, o_logUnsigned},   {31'b0, e_uns});
    check("byte_en",  {28'b0, o_logByteEn},     {28'b0, e_be});
    check("misalign", {31'b0, o_logMisaligned}, {31'b0, e_mis});
    check("bad_size", {31'b0, o_logBadSize},    {31'b0, e_bad});
    check("overrun",  {31'b0, o_overrun},       {31'b0, e_ovr});
    check("load_cnt", o_loadCount,              e_lc);
    check("store_cnt",o_storeCount,             e_sc);
  endtask

  task automatic step(input bit rst, mem, wb, rd, wr, input bit [1:0] sz,
                      input bit sg, input bit [31:0] a, wd, rdat);
    i_reset = rst; en_MEM = mem; en_WB = wb;
    i_ctrlMEM = '{memRead: rd, memWrite: wr, size: sz, sign: sg};
    i_memAddr = a; i_writeData = wd; i_readData = rdat;
    model_edge(rst, mem, wb, rd, wr, sz, sg, a, wd, rdat);
    @(posedge i_clk);
    #1;
    check_all();
  endtask

  task automatic idle(input bit wb);
    step(0, 0, wb, 0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    step(1, 1, 1, 1, 1, SIZE_W, 0, 32'h55, 32'h66, 32'h77);
    step(1, 0, 0, 0, 0, SIZE_B, 0, 0, 0, 0);

    // SW 0x100
    step(0, 1, 0, 0, 1, SIZE_W, 0, 32'h100, 32'hDEADBEEF, 32'h0);
    idle(1);
    check("sw_data", o_logData, 32'hDEADBEEF);
    check("sw_cnt", o_storeCount, 32'd1);
    idle(0);

    // LB signed 0x103, load data arrives after capture
    step(0, 1, 0, 1, 0, SIZE_B, 0, 32'h103, 32'h0, 32'h0);
    step(0, 0, 1, 0, 0, SIZE_B, 0, 32'h0, 32'h0, 32'hFFFFFF80);
    check("lb_be", {28'b0, o_logByteEn}, 32'h8);
    check("lb_data", o_logData, 32'hFFFFFF80);

    // SH misaligned 0x201
    step(0, 1, 0, 0, 1, SIZE_H, 1, 32'h201, 32'h12345678, 32'h0);
    idle(1);
    check("sh_data", o_logData, 32'h00005678);
    check("sh_be", {28'b0, o_logByteEn}, 32'h3);

    // back-to-back capture and emit
    step(0, 1, 1, 1, 0, SIZE_W, 0, 32'h10, 32'h0, 32'hAAAA0000);
    step(0, 1, 1, 0, 1, SIZE_W, 0, 32'h14, 32'hCAFEF00D, 32'h11112222);
    step(0, 0, 1, 0, 0, SIZE_B, 0, 32'h0, 32'h0, 32'h0);
    check("b2b_addr", o_logAddr, 32'h14);
    check("b2b_ovr", {31'b0, o_overrun}, 32'h0);

    // read+write together counts as store; illegal size
    step(0, 1, 0, 1, 1, 2'b11, 0, 32'h2F2, 32'h0BADC0DE, 32'h0);
    idle(1);
    check("bad_flag", {31'b0, o_logBadSize}, 32'h1);

    // two captures without WB -> overrun, second address wins
    step(0, 1, 0, 1, 0, SIZE_W, 1, 32'h300, 32'h0, 32'h0);
    step(0, 1, 0, 1, 0, SIZE_H, 1, 32'h306, 32'h0, 32'h0);
    step(0, 0, 1, 0, 0, SIZE_B, 0, 32'h0, 32'h0, 32'h00C0FFEE);
    check("ovr_addr", o_logAddr, 32'h306);
    check("ovr_flag", {31'b0, o_overrun}, 32'h1);

    // reset with slot full discards the pending record
    step(0, 1, 0, 0, 1, SIZE_W, 0, 32'h400, 32'h1234, 32'h0);
    step(1, 0, 0, 0, 0, SIZE_B, 0, 0, 0, 0);
    idle(1);
    check("rst_valid", {31'b0, o_logValid}, 32'h0);

    for (int i = 0; i < 400; i++) begin
      bit [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           sz, 1'($urandom), $urandom, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
